// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types, coin constants and price lookup for the vending controller
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISPENSE,
        ST_CHANGE,
        ST_REFUND
    } vend_state_e;

    localparam logic [3:0] COIN_1  = 4'd1;
    localparam logic [3:0] COIN_2  = 4'd2;
    localparam logic [3:0] COIN_5  = 4'd5;
    localparam logic [3:0] COIN_10 = 4'd10;

    // Price tables are zero-extended to this width so one function serves any parameterisation
    localparam int PT_MAX_W = 256;

    function automatic logic is_valid_coin(input logic [3:0] c);
        return (c == COIN_1) || (c == COIN_2) || (c == COIN_5) || (c == COIN_10);
    endfunction

    function automatic logic [31:0] price_of(input logic [PT_MAX_W-1:0] tbl,
                                             input int unsigned idx,
                                             input int unsigned w);
        logic [31:0] r;
        r = '0;
        for (int unsigned b = 0; b < 32; b++) begin
            if (b < w && (idx * w + b) < PT_MAX_W) begin
                r[b] = tbl[8'(idx * w + b)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vend_disp_timer.sv
// rtl/vend_disp_timer.sv - down-counter timing the dispense phase
module vend_disp_timer #(
    parameter int DISP_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done
);

    localparam int CNT_W = $clog2(DISP_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = CNT_W'(DISP_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Loaded on the edge that enters DISPENSE, so the last dispense cycle sees a count of one
    assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/vend_ctrl_multi.sv
// rtl/vend_ctrl_multi.sv - multi-product vending controller with credit, change and refund
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int                          NUM_PROD   = 4,
    parameter int                          PRICE_W    = 8,
    parameter logic [NUM_PROD*PRICE_W-1:0] PRICES     = {8'd25, 8'd20, 8'd15, 8'd10},
    parameter int                          DISP_CYC   = 16,
    parameter logic [PRICE_W-1:0]          MAX_CREDIT = 8'd50
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        coin_valid,
    input  logic [3:0]                  coin_in,
    input  logic                        sel_valid,
    input  logic [$clog2(NUM_PROD)-1:0] sel_id,
    input  logic                        cancel,
    output logic                        dispense,
    output logic [$clog2(NUM_PROD)-1:0] dispense_id,
    output logic                        bad_coin,
    output logic                        short_credit,
    output logic                        change_valid,
    output logic [PRICE_W-1:0]          change_amt,
    output logic [PRICE_W-1:0]          credit,
    output logic                        busy
);

    localparam int SEL_W = $clog2(NUM_PROD);

    vend_state_e        state_q, state_d;
    logic [PRICE_W-1:0] credit_q, credit_d;
    logic [PRICE_W-1:0] hold_q, hold_d;
    logic [PRICE_W-1:0] chg_amt_q, chg_amt_d;
    logic [SEL_W-1:0]   id_q, id_d;
    logic               disp_q, disp_d;
    logic               bad_q, bad_d;
    logic               short_q, short_d;
    logic               chg_valid_q, chg_valid_d;
    logic               busy_q, busy_d;

    logic               timer_start;
    logic               timer_done;
    logic [PRICE_W:0]   coin_sum;
    logic               coin_ok;
    logic [PRICE_W-1:0] price;
    logic               sel_ok;

    vend_disp_timer #(.DISP_CYC(DISP_CYC)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (timer_start),
        .done  (timer_done)
    );

    // One extra bit on the sum so an overflowing coin is caught rather than wrapped
    assign coin_sum = {1'b0, credit_q} + (PRICE_W+1)'(coin_in);
    assign coin_ok  = is_valid_coin(coin_in) && (coin_sum <= {1'b0, MAX_CREDIT});
    assign price    = PRICE_W'(price_of(PT_MAX_W'(PRICES), 32'(sel_id), PRICE_W));
    assign sel_ok   = (32'(sel_id) < 32'(NUM_PROD)) && (credit_q >= price);

    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        hold_d      = hold_q;
        id_d        = id_q;
        bad_d       = 1'b0;
        short_d     = 1'b0;
        timer_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cancel && credit_q != '0) begin
                    state_d  = ST_REFUND;
                    hold_d   = credit_q;
                    credit_d = '0;
                    bad_d    = coin_valid;
                end else if (sel_valid) begin
                    bad_d = coin_valid;
                    if (sel_ok) begin
                        state_d     = ST_DISPENSE;
                        id_d        = sel_id;
                        hold_d      = credit_q - price;
                        credit_d    = '0;
                        timer_start = 1'b1;
                    end else begin
                        short_d = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_ok) begin
                        credit_d = coin_sum[PRICE_W-1:0];
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            ST_DISPENSE: begin
                bad_d = coin_valid;
                if (timer_done) begin
                    state_d = (hold_q != '0) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE, ST_REFUND: begin
                bad_d   = coin_valid;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs follow the next state so they line up with state_q after the edge
        disp_d      = (state_d == ST_DISPENSE);
        busy_d      = (state_d != ST_IDLE);
        chg_valid_d = (state_d == ST_CHANGE) || (state_d == ST_REFUND);
        chg_amt_d   = chg_valid_d ? hold_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            credit_q    <= '0;
            hold_q      <= '0;
            chg_amt_q   <= '0;
            id_q        <= '0;
            disp_q      <= 1'b0;
            bad_q       <= 1'b0;
            short_q     <= 1'b0;
            chg_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            hold_q      <= hold_d;
            chg_amt_q   <= chg_amt_d;
            id_q        <= id_d;
            disp_q      <= disp_d;
            bad_q       <= bad_d;
            short_q     <= short_d;
            chg_valid_q <= chg_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign dispense     = disp_q;
    assign dispense_id  = id_q;
    assign bad_coin     = bad_q;
    assign short_credit = short_q;
    assign change_valid = chg_valid_q;
    assign change_amt   = chg_amt_q;
    assign credit       = credit_q;
    assign busy         = busy_q;

endmodule
